microseq_ctrl: RTL
==================

Name: microseq_ctrl

Overview:
- Parametrised microcoded control unit for the 8-bit computer; successor to the fixed combinational control decoder.
- Holds a writable microcode store indexed by {opcode, step} and runs an internal T-state counter.
- Drives one control word per clock to the bus/ALU/register datapath.
- Microcode is loaded in program mode, executed in run mode, and stops on a halt micro-op.

Parameters:
- OPW, 4, opcode width taken from the instruction register.
- STEPS, 6, maximum microsteps per instruction (T0..T(STEPS-1)); 2 <= STEPS <= 16.
- CW, 16, control word width; CW >= 4.
- SW, $clog2(STEPS), step counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous and active-high.
- pmode  in  1  1 = program mode (microcode load), 0 = run mode.
- instr  in  OPW  current opcode from the instruction register.
- run_en  in  1  step enable; 0 stalls the sequencer in place.
- uc_we  in  1  microcode write strobe (honoured in PROG only).
- uc_addr  in  OPW+SW  write address {opcode, step}.
- uc_wdata  in  CW  control word to write.
- ctrl  out  CW  active control word.
- step  out  SW  current T-state.
- halted  out  1  high while in HALT.

Behaviour:
- Microcode store: 2^(OPW+SW) x CW.
  - Synchronous write, asynchronous read.
  - Contents are not cleared by clr.
- Word format:
  - bit CW-1 = END (last step of instruction).
  - bit CW-2 = HLT.
  - bits CW-3..0 = datapath controls.
  - END and HLT are also driven on ctrl.
- States: PROG, RUN, HALT.
- Reset (async): state=PROG, step=0, halted=0; ctrl=0 for as long as clr is high.
- ctrl (combinational):
  - RUN: ctrl = uc[{instr, step}].
  - PROG and HALT: ctrl = 0.
- PROG:
  - Write occurs on clk when uc_we=1.
  - step held at 0.
  - If pmode=0 at a clk edge, next state is RUN with step=0.
- RUN, clk edge with pmode=1: next state PROG, step=0; this has priority over everything else.
- RUN, clk edge with run_en=0: no change.
- RUN, clk edge with run_en=1 (priority order):
  - HLT set: next state HALT, step unchanged.
  - Else END set, or step==STEPS-1: step wraps to 0.
  - Else step+1.
- HALT:
  - halted=1; writes are ignored.
  - Leaves only by pmode=1 at a clk edge (to PROG, step=0, halted=0) or by clr.
- uc_we outside PROG: ignored, store unchanged.
- uc_addr step field >= STEPS: write still lands, but that word is never read.
- Opcode change mid-instruction: ctrl follows instr combinationally; the step count is not restarted.
- Reset mid-instruction: immediate return to PROG/step 0; microcode is retained.

Optional Feature:
- Macro: CU_INSTR_COUNT_EN.
- Defined:
  - Adds output port icount (16 bits), reset to 0 by clr.
  - Increments on each RUN clk edge with run_en=1 where step wraps to 0 via END or STEPS-1.
  - Saturates at 16'hFFFF.
  - Cleared on entry to PROG.
- Not defined: port absent, no counter logic.

Test Plan:
- Program load:
  - Stimulus: clr pulse, pmode=1; write uc[{4'h1,3'd0}]=16'h0102, uc[{4'h1,3'd1}]=16'h8004; then pmode=0, instr=4'h1, run_en=1.
  - Response: ctrl=16'h0102 at step 0, 16'h8004 at step 1, then step wraps to 0 with ctrl=16'h0102.
- Full-length wrap:
  - Stimulus: opcode 4'h2 with no END in any of its 6 words.
  - Response: step sequence 0,1,2,3,4,5,0.
- Stall:
  - Stimulus: run_en=0 for 3 clocks at step 2.
  - Response: step and ctrl stay constant; run_en=1 resumes at step 3.
- Halt:
  - Stimulus: uc[{4'hF,3'd2}]=16'h4000; run opcode 4'hF.
  - Response: halted=1 after the step-2 edge and ctrl=0. A write attempt with uc_we=1 leaves the store unchanged. pmode=1 then returns to PROG with halted=0.
- Async reset mid-run:
  - Stimulus: clr asserted between edges at step 3.
  - Response: step=0 and ctrl=0 immediately. After release with pmode=0, step 0 of the same opcode reads the previously loaded word.
- CU_INSTR_COUNT_EN:
  - Stimulus: 5 complete 2-step instructions.
  - Response: icount=5; pmode=1 clears it to 0.

Source files
------------

// File: rtl/microseq_ctrl_if.sv
// Bus bundle for microseq_ctrl: program/run controls, microcode write port and control-word outputs.
// The icount signal exists only when CU_INSTR_COUNT_EN is defined.
interface microseq_ctrl_if #(
    parameter int OPW   = 4,
    parameter int STEPS = 6,
    parameter int CW    = 16
);
    localparam int SW = $clog2(STEPS);

    logic                pmode;
    logic [OPW-1:0]      instr;
    logic                run_en;
    logic                uc_we;
    logic [OPW+SW-1:0]   uc_addr;
    logic [CW-1:0]       uc_wdata;
    logic [CW-1:0]       ctrl;
    logic [SW-1:0]       step;
    logic                halted;
`ifdef CU_INSTR_COUNT_EN
    logic [15:0]         icount;

    modport master (
        output pmode, instr, run_en, uc_we, uc_addr, uc_wdata,
        input  ctrl, step, halted, icount
    );
    modport slave (
        input  pmode, instr, run_en, uc_we, uc_addr, uc_wdata,
        output ctrl, step, halted, icount
    );
`else
    modport master (
        output pmode, instr, run_en, uc_we, uc_addr, uc_wdata,
        input  ctrl, step, halted
    );
    modport slave (
        input  pmode, instr, run_en, uc_we, uc_addr, uc_wdata,
        output ctrl, step, halted
    );
`endif
endinterface

// File: rtl/microseq_ctrl.sv
// Microcoded control unit: writable {opcode, step} store, T-state sequencer, PROG/RUN/HALT modes.
// Optional retired-instruction counter enabled by defining CU_INSTR_COUNT_EN.
module microseq_ctrl #(
    parameter int OPW   = 4,
    parameter int STEPS = 6,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          clr,
    microseq_ctrl_if.slave bus
);
    localparam int SW    = $clog2(STEPS);
    localparam int DEPTH = 2 ** (OPW + SW);
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {PROG, RUN, HALT} state_t;

    state_t        state;
    logic [SW-1:0] step_q;
    logic          halted_q;
    logic [CW-1:0] uc [DEPTH];
    logic [CW-1:0] word;
    logic          wrap_evt;

    // Store has no reset so microcode survives clr.
    always_ff @(posedge clk) begin
        if (state == PROG && bus.uc_we) begin
            uc[bus.uc_addr] <= bus.uc_wdata;
        end
    end

    assign word     = uc[{bus.instr, step_q}];
    assign wrap_evt = (state == RUN) && !bus.pmode && bus.run_en && !word[CW-2]
                      && (word[CW-1] || step_q == LAST);

    assign bus.ctrl   = (state == RUN) ? word : '0;
    assign bus.step   = step_q;
    assign bus.halted = halted_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= PROG;
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                PROG: begin
                    step_q   <= '0;
                    halted_q <= 1'b0;
                    if (!bus.pmode) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.pmode) begin
                        state  <= PROG;
                        step_q <= '0;
                    end else if (bus.run_en) begin
                        if (word[CW-2]) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end else if (wrap_evt) begin
                            step_q <= '0;
                        end else begin
                            step_q <= step_q + SW'(1);
                        end
                    end
                end
                HALT: begin
                    if (bus.pmode) begin
                        state    <= PROG;
                        step_q   <= '0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= PROG;
                    step_q   <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CU_INSTR_COUNT_EN
    logic [15:0] icount_q;

    // Any edge that lands in PROG (held there or entering via pmode) zeroes the count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            icount_q <= '0;
        end else if (state == PROG || bus.pmode) begin
            icount_q <= '0;
        end else if (wrap_evt && icount_q != '1) begin
            icount_q <= icount_q + 16'd1;
        end
    end

    assign bus.icount = icount_q;
`else
    // Default build carries no instruction counter.
`endif

endmodule
